// File: rtl/cpu_pkg.sv
// Shared CPU definitions: reset PC, NOP encoding and fetch FSM state type.
package cpu_pkg;

    localparam logic [31:0] RESET_PC  = 32'h0000_3000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus bundle: PC handshake from program_counter, instruction
// memory request/response, and the instruction handshake toward decode.
// The slave modport is the fetch unit's view; master is the environment's.
interface instr_fetch_unit_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [AW-1:0] pc_in;
    logic          pc_valid;
    logic          pc_ready;
    logic          redirect;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_gnt;
    logic          imem_rvalid;
    logic [DW-1:0] imem_rdata;
    logic          inst_valid;
    logic          inst_ready;
    logic [DW-1:0] inst_out;
    logic [AW-1:0] inst_pc;

    modport slave (
        input  pc_in, pc_valid, redirect, imem_gnt, imem_rvalid, imem_rdata, inst_ready,
        output pc_ready, imem_req, imem_addr, inst_valid, inst_out, inst_pc
    );

    modport master (
        output pc_in, pc_valid, redirect, imem_gnt, imem_rvalid, imem_rdata, inst_ready,
        input  pc_ready, imem_req, imem_addr, inst_valid, inst_out, inst_pc
    );
endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding {pc, instruction} pairs. Clear has priority
// over push/pop; pop on empty and push on full are ignored.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic                         clear_i,
    input  logic [W-1:0]                 data_i,
    output logic [W-1:0]                 data_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         full_o,
    output logic                         empty_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Storage, pointers and occupancy; pointers wrap naturally (DEPTH is a power of two).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (clear_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: single-outstanding memory request per accepted PC,
// responses buffered in fetch_fifo toward decode, flushed on redirect.
// Optional misaligned-PC detection is enabled by defining FETCH_MISALIGN_CHK_EN.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                clk,
    input  logic                rst,
    instr_fetch_unit_if.slave   bus
`ifdef FETCH_MISALIGN_CHK_EN
    ,
    output logic                misalign_err
`endif
);
    localparam int CW = $clog2(DEPTH + 1);

    fetch_state_e  state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] pend_q, pend_d;
    logic          drop_q, drop_d;
    logic          accept, push;
    logic [DW-1:0] push_instr;
    logic [AW+DW-1:0] fifo_rdata;
    logic [CW-1:0] fifo_count;
    logic          fifo_full, fifo_empty;
`ifdef FETCH_MISALIGN_CHK_EN
    logic          mis_q, mis_d;
    logic          err_q, err_d;
    logic          misaligned;

    assign misaligned   = (bus.pc_in[1:0] != 2'b00);
    assign misalign_err = err_q;
`endif

    // A new PC is only taken in IDLE with a free slot, so every response has room.
    assign bus.pc_ready   = (state_q == IDLE) && (fifo_count < CW'(DEPTH)) && !bus.redirect && !rst;
    assign accept         = bus.pc_valid && bus.pc_ready;
    assign bus.imem_req   = (state_q == REQ);
    assign bus.imem_addr  = addr_q;
    assign bus.inst_valid = !fifo_empty;
    assign {bus.inst_pc, bus.inst_out} = fifo_rdata;

    // Next-state logic: request hand-off, response capture and redirect squashing.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        pend_d     = pend_q;
        drop_d     = drop_q;
        push       = 1'b0;
        push_instr = bus.imem_rdata;
`ifdef FETCH_MISALIGN_CHK_EN
        mis_d      = mis_q;
        err_d      = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    pend_d = bus.pc_in;
`ifdef FETCH_MISALIGN_CHK_EN
                    if (misaligned) begin
                        mis_d   = 1'b1;
                        err_d   = 1'b1;
                        state_d = WAIT;
                    end else begin
                        addr_d  = bus.pc_in;
                        state_d = REQ;
                    end
`else
                    addr_d  = bus.pc_in;
                    state_d = REQ;
`endif
                end
            end
            REQ: begin
                if (bus.redirect) begin
                    // A grant in the redirect cycle still yields a response that must be eaten.
                    state_d = bus.imem_gnt ? WAIT : IDLE;
                    drop_d  = bus.imem_gnt;
                end else if (bus.imem_gnt) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
`ifdef FETCH_MISALIGN_CHK_EN
                if (mis_q) begin
                    push       = !bus.redirect;
                    push_instr = NOP_INSTR;
                    mis_d      = 1'b0;
                    state_d    = IDLE;
                end else
`endif
                if (bus.imem_rvalid) begin
                    push    = !drop_q && !bus.redirect;
                    drop_d  = 1'b0;
                    state_d = IDLE;
                end else if (bus.redirect) begin
                    drop_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and address registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            pend_q  <= '0;
            drop_q  <= 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
            mis_q   <= 1'b0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            pend_q  <= pend_d;
            drop_q  <= drop_d;
`ifdef FETCH_MISALIGN_CHK_EN
            mis_q   <= mis_d;
            err_q   <= err_d;
`endif
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .W     (AW + DW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (bus.inst_valid && bus.inst_ready),
        .clear_i (bus.redirect),
        .data_i  ({pend_q, push_instr}),
        .data_o  (fifo_rdata),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // A full FIFO must never coincide with an open PC port.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst) fifo_full |-> !bus.pc_ready);
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed testbench for instr_fetch_unit: inputs driven on the falling edge,
// outputs sampled on the falling edge.
module tb_instr_fetch_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   gnt_cnt = 0;

    instr_fetch_unit_if #(.AW(32), .DW(32)) bus ();
`ifdef FETCH_MISALIGN_CHK_EN
    logic misalign_err;
`endif

    instr_fetch_unit #(.DEPTH(4), .AW(32), .DW(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef FETCH_MISALIGN_CHK_EN
        ,
        .misalign_err (misalign_err)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (bus.imem_req && bus.imem_gnt) gnt_cnt++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic do_fetch(input logic [31:0] pc, input logic [31:0] data, input int gdly, input int rdly);
        int n;
        @(negedge clk);
        bus.pc_in = pc;
        bus.pc_valid = 1'b1;
        n = 0;
        while (!bus.pc_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 20) begin
            errors++;
            $display("FAIL fetch_accept: pc_ready stayed 0 for pc %h, required 1", pc);
        end
        @(negedge clk);
        bus.pc_valid = 1'b0;
        repeat (gdly) @(negedge clk);
        bus.imem_gnt = 1'b1;
        @(negedge clk);
        bus.imem_gnt = 1'b0;
        repeat (rdly) @(negedge clk);
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata = data;
        @(negedge clk);
        bus.imem_rvalid = 1'b0;
    endtask

    task automatic test_reset();
        bus.pc_in = '0; bus.pc_valid = 0; bus.redirect = 0; bus.imem_gnt = 0;
        bus.imem_rvalid = 0; bus.imem_rdata = '0; bus.inst_ready = 0;
        rst = 1'b1;
        #13;
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b expected 0", bus.imem_req); end
        checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h expected 0", bus.imem_addr); end
        checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", bus.inst_valid); end
        checks++; if (bus.inst_out !== 32'h0) begin errors++; $display("FAIL rst_out: got %h expected 0", bus.inst_out); end
        checks++; if (bus.inst_pc !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h expected 0", bus.inst_pc); end
        checks++; if (bus.pc_ready !== 1'b0) begin errors++; $display("FAIL rst_pc_ready: got %b expected 0", bus.pc_ready); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (bus.pc_ready !== 1'b1) begin errors++; $display("FAIL post_rst_pc_ready: got %b expected 1", bus.pc_ready); end
    endtask

    task automatic test_single_fetch();
        @(negedge clk);
        bus.pc_in = 32'h0000_3000;
        bus.pc_valid = 1'b1;
        @(negedge clk);
        bus.pc_valid = 1'b0;
        checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL single_req: got %b expected 1", bus.imem_req); end
        checks++; if (bus.imem_addr !== 32'h3000) begin errors++; $display("FAIL single_addr: got %h expected 3000", bus.imem_addr); end
        checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL single_early1: got %b expected 0", bus.inst_valid); end
        bus.imem_gnt = 1'b1;
        @(negedge clk);
        bus.imem_gnt = 1'b0;
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL single_req_drop: got %b expected 0", bus.imem_req); end
        checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL single_early2: got %b expected 0", bus.inst_valid); end
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata = 32'h2008_0005;
        @(negedge clk);
        bus.imem_rvalid = 1'b0;
        checks++; if (bus.inst_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", bus.inst_valid); end
        checks++; if (bus.inst_out !== 32'h2008_0005) begin errors++; $display("FAIL single_out: got %h expected 20080005", bus.inst_out); end
        checks++; if (bus.inst_pc !== 32'h3000) begin errors++; $display("FAIL single_pc: got %h expected 3000", bus.inst_pc); end
        bus.inst_ready = 1'b1;
        @(negedge clk);
        bus.inst_ready = 1'b0;
        checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL single_pop: got %b expected 0", bus.inst_valid); end
    endtask

    task automatic test_backpressure();
        bus.inst_ready = 1'b0;
        for (int i = 0; i < 4; i++) do_fetch(32'h3000 + 32'(4 * i), 32'h1000_0000 + 32'(i), 0, 0);
        #1;
        checks++; if (bus.pc_ready !== 1'b0) begin errors++; $display("FAIL full_pc_ready: got %b expected 0", bus.pc_ready); end
        checks++; if (bus.inst_pc !== 32'h3000) begin errors++; $display("FAIL full_head: got %h expected 3000", bus.inst_pc); end
        bus.inst_ready = 1'b1;
        @(negedge clk);
        bus.inst_ready = 1'b0;
        #1;
        checks++; if (bus.pc_ready !== 1'b1) begin errors++; $display("FAIL after_pop_pc_ready: got %b expected 1", bus.pc_ready); end
        for (int i = 1; i < 4; i++) begin
            checks++; if (bus.inst_pc !== 32'h3000 + 32'(4 * i)) begin errors++; $display("FAIL drain_pc%0d: got %h expected %h", i, bus.inst_pc, 32'h3000 + 32'(4 * i)); end
            checks++; if (bus.inst_out !== 32'h1000_0000 + 32'(i)) begin errors++; $display("FAIL drain_out%0d: got %h expected %h", i, bus.inst_out, 32'h1000_0000 + 32'(i)); end
            bus.inst_ready = 1'b1;
            @(negedge clk);
            bus.inst_ready = 1'b0;
        end
        checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL drain_empty: got %b expected 0", bus.inst_valid); end
    endtask

    task automatic test_gnt_delay();
        int g0;
        @(negedge clk);
        bus.pc_in = 32'h3004;
        bus.pc_valid = 1'b1;
        @(negedge clk);
        bus.pc_valid = 1'b0;
        bus.pc_in = 32'hFFFF_FFFC;
        g0 = gnt_cnt;
        for (int i = 0; i < 5; i++) begin
            checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h3004) begin
                errors++; $display("FAIL gnt_hold%0d: req %b addr %h expected req 1 addr 3004", i, bus.imem_req, bus.imem_addr);
            end
            @(negedge clk);
        end
        bus.imem_gnt = 1'b1;
        @(negedge clk);
        bus.imem_gnt = 1'b0;
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL gnt_req_drop: got %b expected 0", bus.imem_req); end
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata = 32'h0041_0113;
        @(negedge clk);
        bus.imem_rvalid = 1'b0;
        checks++; if (gnt_cnt - g0 !== 1) begin errors++; $display("FAIL gnt_count: got %0d expected 1", gnt_cnt - g0); end
        checks++; if (bus.inst_pc !== 32'h3004 || bus.inst_out !== 32'h0041_0113) begin
            errors++; $display("FAIL gnt_result: pc %h out %h expected 3004 00410113", bus.inst_pc, bus.inst_out);
        end
        bus.inst_ready = 1'b1;
        @(negedge clk);
        bus.inst_ready = 1'b0;
    endtask

    task automatic test_redirect_wait();
        @(negedge clk);
        bus.pc_in = 32'h3010;
        bus.pc_valid = 1'b1;
        @(negedge clk);
        bus.pc_valid = 1'b0;
        bus.imem_gnt = 1'b1;
        @(negedge clk);
        bus.imem_gnt = 1'b0;
        bus.redirect = 1'b1;
        @(negedge clk);
        bus.redirect = 1'b0;
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL rdw_req: got %b expected 0", bus.imem_req); end
        @(negedge clk);
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.imem_rvalid = 1'b0;
        #1;
        checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL rdw_dropped: got %b expected 0", bus.inst_valid); end
        checks++; if (bus.pc_ready !== 1'b1) begin errors++; $display("FAIL rdw_idle: got %b expected 1", bus.pc_ready); end
        do_fetch(32'h3040, 32'h00A0_0093, 0, 0);
        checks++; if (bus.inst_pc !== 32'h3040 || bus.inst_out !== 32'h00A0_0093) begin
            errors++; $display("FAIL rdw_next: pc %h out %h expected 3040 00a00093", bus.inst_pc, bus.inst_out);
        end
        bus.inst_ready = 1'b1;
        @(negedge clk);
        bus.inst_ready = 1'b0;
        checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL rdw_single_entry: got %b expected 0", bus.inst_valid); end
    endtask

    task automatic test_redirect_flush();
        bus.inst_ready = 1'b0;
        for (int i = 0; i < 3; i++) do_fetch(32'h3100 + 32'(4 * i), 32'h5000_0000 + 32'(i), 0, 0);
        checks++; if (bus.inst_valid !== 1'b1) begin errors++; $display("FAIL flush_pre: got %b expected 1", bus.inst_valid); end
        bus.redirect = 1'b1;
        bus.inst_ready = 1'b1;
        #1;
        checks++; if (bus.pc_ready !== 1'b0) begin errors++; $display("FAIL flush_pc_ready: got %b expected 0", bus.pc_ready); end
        @(negedge clk);
        bus.redirect = 1'b0;
        bus.inst_ready = 1'b0;
        #1;
        checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b expected 0", bus.inst_valid); end
        checks++; if (bus.pc_ready !== 1'b1) begin errors++; $display("FAIL flush_pc_ready_after: got %b expected 1", bus.pc_ready); end
        do_fetch(32'h3200, 32'h7777_0001, 1, 2);
        checks++; if (bus.inst_pc !== 32'h3200 || bus.inst_out !== 32'h7777_0001) begin
            errors++; $display("FAIL flush_refill: pc %h out %h expected 3200 77770001", bus.inst_pc, bus.inst_out);
        end
        bus.inst_ready = 1'b1;
        @(negedge clk);
        bus.inst_ready = 1'b0;
        checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL flush_refill_empty: got %b expected 0", bus.inst_valid); end
    endtask

`ifdef FETCH_MISALIGN_CHK_EN
    task automatic test_misalign();
        @(negedge clk);
        bus.pc_in = 32'h3002;
        bus.pc_valid = 1'b1;
        @(negedge clk);
        bus.pc_valid = 1'b0;
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL mis_req: got %b expected 0", bus.imem_req); end
        checks++; if (misalign_err !== 1'b1) begin errors++; $display("FAIL mis_err: got %b expected 1", misalign_err); end
        @(negedge clk);
        checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h3002 || bus.inst_out !== 32'h0) begin
            errors++; $display("FAIL mis_push: valid %b pc %h out %h expected 1 3002 0", bus.inst_valid, bus.inst_pc, bus.inst_out);
        end
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL mis_req2: got %b expected 0", bus.imem_req); end
        bus.inst_ready = 1'b1;
        @(negedge clk);
        bus.inst_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (misalign_err !== 1'b1) begin errors++; $display("FAIL mis_sticky: got %b expected 1", misalign_err); end
        rst = 1'b1;
        #1;
        checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL mis_rst: got %b expected 0", misalign_err); end
        @(negedge clk);
        rst = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_single_fetch();
        test_backpressure();
        test_gnt_delay();
        test_redirect_wait();
        test_redirect_flush();
`ifdef FETCH_MISALIGN_CHK_EN
        test_misalign();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage between program_counter and decode.
- Accepts one PC per handshake and issues a single-outstanding request to instruction memory with variable latency.
- Buffers returned {pc, instruction} pairs in a small FIFO and presents them to decode with valid/ready.
- Flushes the FIFO and drops any in-flight response on a redirect (taken branch).

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- AW, 32, address/PC width.
- DW, 32, instruction width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- pc_in  in  AW  fetch address from program_counter.
- pc_valid  in  1  pc_in is valid.
- pc_ready  out  1  unit can accept pc_in this cycle.
- redirect  in  1  flush: discard all buffered and in-flight fetches.
- imem_req  out  1  memory request.
- imem_addr  out  AW  request address; held stable while imem_req is high.
- imem_gnt  in  1  memory accepted the request.
- imem_rvalid  in  1  read data valid.
- imem_rdata  in  DW  read data.
- inst_valid  out  1  FIFO head valid.
- inst_ready  in  1  decode consumes the head.
- inst_out  out  DW  head instruction.
- inst_pc  out  AW  head PC.
- misalign_err  out  1  present only with FETCH_MISALIGN_CHK_EN.

Behaviour:
- Reset (async, takes effect immediately):
  - FSM = IDLE, FIFO empty (rd_ptr, wr_ptr, count = 0), drop flag = 0.
  - imem_req = 0, imem_addr = 0, inst_valid = 0, inst_out = 0, inst_pc = 0, misalign_err = 0.
  - pc_ready is forced to 0 while rst is high.
- FSM states: IDLE, REQ, WAIT.
  - IDLE: pc_ready = (count < DEPTH) && !redirect. On pc_valid && pc_ready, latch pc_in into imem_addr and a pending-PC register, set imem_req = 1 → REQ.
  - REQ: imem_req stays 1 and imem_addr stays stable until imem_gnt. On gnt: imem_req = 0 → WAIT.
  - WAIT: on imem_rvalid, push {pending PC, imem_rdata} unless the drop flag is set → IDLE. If the drop flag is set, discard the data, clear the flag → IDLE.
- Credit rule: only one request is in flight. pc_ready is evaluated in IDLE only, with count < DEPTH, so the push slot is guaranteed and the FIFO never overflows.
- Latency:
  - Minimum PC-accept to inst_valid is 3 cycles: accept → REQ with same-cycle gnt → WAIT with rvalid → head visible the next cycle.
  - Throughput is one instruction per 3 cycles at best.
- FIFO:
  - inst_valid = (count != 0); inst_out and inst_pc are driven from the head entry.
  - A pop occurs on inst_valid && inst_ready.
  - Simultaneous push and pop leaves count unchanged; pointers wrap modulo DEPTH.
  - Pop when empty is ignored.
- Redirect (highest priority, takes effect at the clock edge):
  - FIFO cleared (count = 0, pointers = 0). A same-cycle pop and push are both discarded.
  - In REQ: imem_req is dropped at that edge. If imem_gnt was high in the same cycle, go to WAIT with drop = 1; otherwise go to IDLE.
  - In WAIT without same-cycle rvalid: drop = 1. With same-cycle rvalid: data discarded → IDLE.
  - In IDLE: pc_ready = 0 that cycle, so no new PC is accepted until the next cycle.
- No arithmetic on addresses: imem_addr = pc_in verbatim.

Optional Feature:
- Macro: FETCH_MISALIGN_CHK_EN.
- Defined:
  - An accepted pc_in with pc_in[1:0] != 0 issues no memory request.
  - Next cycle the unit pushes {pc_in, 32'h0000_0000}, i.e. a NOP, then returns to IDLE.
  - misalign_err becomes sticky 1; only rst clears it.
- Undefined:
  - misalign_err port is absent.
  - Low address bits are passed to memory unchecked.

Decomposition:
- Shared package cpu_pkg:
  - RESET_PC = 32'h0000_3000.
  - NOP_INSTR = 32'h0000_0000.
  - fetch FSM state enum {IDLE, REQ, WAIT}.
- Sub-module fetch_fifo: parameterized DEPTH × (AW+DW) synchronous FIFO with push, pop, clear, count, full and empty. Instantiated once.

Test Plan:
- Reset then pc_in = 0x3000, gnt and rvalid each in one cycle with rdata = 0x2008_0005 → imem_addr = 0x3000; 3 cycles later inst_valid = 1, inst_out = 0x2008_0005, inst_pc = 0x3000.
- Hold inst_ready = 0 while fetching 0x3000, 0x3004, 0x3008, 0x300C → after 4 entries pc_ready = 0. Pop one → pc_ready = 1. Order is preserved on drain.
- gnt delayed 5 cycles → imem_req and imem_addr = 0x3004 are held stable throughout; exactly one request.
- Redirect in WAIT, rvalid 2 cycles later with 0xDEAD_BEEF → no push. Next fetch 0x3040 returns correctly; FIFO was empty after the redirect.
- Redirect with 3 entries buffered plus a same-cycle inst_ready → count = 0, inst_valid = 0 next cycle.
- With FETCH_MISALIGN_CHK_EN, pc_in = 0x3002 → imem_req stays 0; entry {0x3002, 0x0} is pushed; misalign_err = 1 and persists until rst.
